// File: rtl/nios_mul_pkg.sv
// Shared constants and the result entry type for the multiplier low-word combine path.
package nios_mul_pkg;

  localparam int DATA_W     = 32;
  localparam int HALF_W     = DATA_W / 2;
  localparam int REG_W      = 5;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0]  dst;
  } mul_entry_t;

endpackage

// File: rtl/nios_mul_result_fifo.sv
// Result queue for writeback: pointers carry an extra wrap bit so count distinguishes full from empty.
module nios_mul_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] head;
  logic             do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign do_pop  = pop_i && (count_o != '0);

  // When empty, present the most recently shown head rather than a stale slot.
  assign rdata_o = (count_o != '0) ? head : last_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + CNT_W'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (count_o != '0) last_q <= head;
      if (push_i && !clear_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/nios_mul_result_combine.sv
// Merges the three registered 16x16 partial products into the 32-bit low-word MUL result,
// two pipeline stages feeding a credit-controlled result FIFO.
module nios_mul_result_combine #(
  parameter int DATA_W     = nios_mul_pkg::DATA_W,
  parameter int REG_W      = nios_mul_pkg::REG_W,
  parameter int FIFO_DEPTH = nios_mul_pkg::FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_p1,
  input  logic [DATA_W-1:0]           in_p2,
  input  logic [DATA_W-1:0]           in_p3,
  input  logic [REG_W-1:0]            in_dst,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_result,
  output logic [REG_W-1:0]            out_dst,
  output logic [$clog2(FIFO_DEPTH):0] out_count
);

  import nios_mul_pkg::*;

  localparam int HALF  = DATA_W / 2;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic              s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0] s1_p1_q, s1_p1_d;
  logic [HALF-1:0]   s1_mid_q, s1_mid_d;
  logic [REG_W-1:0]  s1_dst_q, s1_dst_d;
  logic              s2_vld_q, s2_vld_d;
  mul_entry_t        s2_q, s2_d;
  mul_entry_t        head;
  logic [SUM_W-1:0]  in_flight;
  logic              accept;
  logic              unused_hi;

  // Only the low halves of the cross products reach the low word.
  assign unused_hi = ^{in_p2[DATA_W-1:HALF], in_p3[DATA_W-1:HALF]};

  // Credits count every entry already committed to the FIFO, from registered state only.
  assign in_flight = SUM_W'(out_count) + SUM_W'(s1_vld_q) + SUM_W'(s2_vld_q);
  assign in_ready  = in_flight < SUM_W'(FIFO_DEPTH);
  assign accept    = in_valid && in_ready && !flush;

  always_comb begin
    s1_vld_d = accept;
    s1_p1_d  = s1_p1_q;
    s1_mid_d = s1_mid_q;
    s1_dst_d = s1_dst_q;
    if (accept) begin
      s1_p1_d  = in_p1;
      s1_mid_d = in_p2[HALF-1:0] + in_p3[HALF-1:0];
      s1_dst_d = in_dst;
    end
    s2_vld_d = s1_vld_q && !flush;
    s2_d     = s2_q;
    if (s1_vld_q) begin
      s2_d.result = s1_p1_q + {s1_mid_q, {HALF{1'b0}}};
      s2_d.dst    = s1_dst_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q <= 1'b0;
      s1_p1_q  <= '0;
      s1_mid_q <= '0;
      s1_dst_q <= '0;
      s2_vld_q <= 1'b0;
      s2_q     <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_p1_q  <= s1_p1_d;
      s1_mid_q <= s1_mid_d;
      s1_dst_q <= s1_dst_d;
      s2_vld_q <= s2_vld_d;
      s2_q     <= s2_d;
    end
  end

  nios_mul_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(mul_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (s2_vld_q),
    .pop_i   (out_valid && out_ready),
    .clear_i (flush),
    .wdata_i (s2_q),
    .rdata_o (head),
    .count_o (out_count)
  );

  assign out_valid  = out_count != '0;
  assign out_result = head.result;
  assign out_dst    = head.dst;

endmodule

// File: tb/tb_nios_mul_result_combine.sv
// Directed self-checking bench for nios_mul_result_combine.
module tb_nios_mul_result_combine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_p1, in_p2, in_p3;
  logic [4:0]  in_dst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_dst;
  logic [2:0]  out_count;

  int compared   = 0;
  int mismatched = 0;

  nios_mul_result_combine dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_p1      (in_p1),
    .in_p2      (in_p2),
    .in_p3      (in_p3),
    .in_dst     (in_dst),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_dst    (out_dst),
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] mulLow(input logic [31:0] a, input logic [31:0] b);
    return a * b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drive_pp(input logic [31:0] p1, input logic [31:0] p2,
                          input logic [31:0] p3, input logic [4:0] dst);
    in_valid = 1'b1;
    in_p1    = p1;
    in_p2    = p2;
    in_p3    = p3;
    in_dst   = dst;
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] dst);
    logic [31:0] alo, ahi, blo, bhi;
    alo = {16'h0, a[15:0]};
    ahi = {16'h0, a[31:16]};
    blo = {16'h0, b[15:0]};
    bhi = {16'h0, b[31:16]};
    drive_pp(alo * blo, alo * bhi, ahi * blo, dst);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_p1     = '0;
    in_p2     = '0;
    in_p3     = '0;
    in_dst    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
    compared++;
    if (out_count !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d want 0", out_count); end
    compared++;
    if (out_result !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_result: got %h want 0", out_result); end
    compared++;
    if (out_dst !== 5'h0) begin mismatched++; $display("[TB] FAIL reset_dst: got %h want 0", out_dst); end
    reset_n = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive_pp(32'd15, 32'd2, 32'd2, 5'h0A);
    step();
    idle();
    for (int c = 0; c < 2; c++) begin
      compared++;
      if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_early c=%0d: got %b want 0", c, out_valid); end
      step();
    end
    compared++;
    if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_valid: got %b want 1", out_valid); end
    compared++;
    if (out_result !== 32'h0004_000F) begin mismatched++; $display("[TB] FAIL single_result: got %h want 0004000f", out_result); end
    compared++;
    if (out_dst !== 5'h0A) begin mismatched++; $display("[TB] FAIL single_dst: got %h want 0a", out_dst); end
    compared++;
    if (out_count !== 3'd1) begin mismatched++; $display("[TB] FAIL single_count: got %0d want 1", out_count); end
    step();
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_popped: got %b want 0", out_valid); end
    compared++;
    if (out_result !== 32'h0004_000F) begin mismatched++; $display("[TB] FAIL single_hold: got %h want 0004000f", out_result); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    drive_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h11);
    compared++;
    if (in_p2 !== 32'hFFFE_0001) begin mismatched++; $display("[TB] FAIL wrap_stim: got %h want fffe0001", in_p2); end
    step();
    idle();
    step();
    step();
    compared++;
    if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_valid: got %b want 1", out_valid); end
    compared++;
    if (out_result !== 32'h0000_0001) begin mismatched++; $display("[TB] FAIL wrap_result: got %h want 00000001", out_result); end
    compared++;
    if (out_dst !== 5'h11) begin mismatched++; $display("[TB] FAIL wrap_dst: got %h want 11", out_dst); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [8];
    logic [31:0] b [8];
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a[i] = 32'h1234_5678 + i * 32'h0101_0307;
      b[i] = 32'h9ABC_DEF1 - i * 32'h0031_1103;
    end
    for (int i = 0; i < 14; i++) begin
      if (i < 8) begin
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_ready i=%0d: got %b want 1", i, in_ready); end
        drive_op(a[i], b[i], 5'(i + 3));
      end else begin
        idle();
      end
      if (i >= 3 && i <= 10) begin
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_valid i=%0d: got %b want 1", i, out_valid); end
        compared++;
        if (out_result !== mulLow(a[i-3], b[i-3])) begin
          mismatched++; $display("[TB] FAIL b2b_result n=%0d: got %h want %h", i - 3, out_result, mulLow(a[i-3], b[i-3]));
        end
        compared++;
        if (out_dst !== 5'(i)) begin mismatched++; $display("[TB] FAIL b2b_dst n=%0d: got %h want %h", i - 3, out_dst, 5'(i)); end
      end
      if (i == 11) begin
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_tail: got %b want 0", out_valid); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] expRes [$];
    logic [4:0]  expDst [$];
    int accepted = 0;
    int got = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_op(32'h0000_1000 + i * 32'h0003_0011, 32'h0007_0020 + i, 5'(5'h10 + i));
      if (in_ready) begin
        accepted++;
        expRes.push_back(mulLow(32'h0000_1000 + i * 32'h0003_0011, 32'h0007_0020 + i));
        expDst.push_back(5'(5'h10 + i));
      end
      step();
    end
    idle();
    compared++;
    if (accepted != 4) begin mismatched++; $display("[TB] FAIL bp_accepted: got %0d want 4", accepted); end
    compared++;
    if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_ready: got %b want 0", in_ready); end
    compared++;
    if (out_count !== 3'd4) begin mismatched++; $display("[TB] FAIL bp_count: got %0d want 4", out_count); end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1) begin
        compared++;
        if (got >= expRes.size()) begin
          mismatched++; $display("[TB] FAIL bp_extra: got entry %0d want none", got);
        end else if (out_result !== expRes[got] || out_dst !== expDst[got]) begin
          mismatched++;
          $display("[TB] FAIL bp_drain n=%0d: got %h/%h want %h/%h", got, out_result, out_dst, expRes[got], expDst[got]);
        end
        got++;
      end
      step();
    end
    compared++;
    if (got != 4) begin mismatched++; $display("[TB] FAIL bp_drained: got %0d want 4", got); end
    compared++;
    if (out_count !== 3'd0) begin mismatched++; $display("[TB] FAIL bp_empty: got %0d want 0", out_count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_op(32'h0000_0100 + i, 32'h0000_0200 + i, 5'(5'h18 + i));
      step();
    end
    compared++;
    if (out_count !== 3'd2) begin mismatched++; $display("[TB] FAIL flush_pre_count: got %0d want 2", out_count); end
    drive_op(32'h0000_0333, 32'h0000_0444, 5'h1F);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_valid: got %b want 0", out_valid); end
    compared++;
    if (out_count !== 3'd0) begin mismatched++; $display("[TB] FAIL flush_count: got %0d want 0", out_count); end
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_ready: got %b want 1", in_ready); end
    drive_op(32'h0000_0555, 32'h0000_0666, 5'h1E);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      compared++;
      if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_leak c=%0d: got valid tag %h want none", c, out_dst); end
      step();
    end
    drive_op(32'h0002_0003, 32'h0004_0005, 5'h05);
    step();
    idle();
    step();
    step();
    compared++;
    if (out_valid !== 1'b1 || out_result !== 32'h0016_000F || out_dst !== 5'h05) begin
      mismatched++;
      $display("[TB] FAIL flush_fresh: got %b/%h/%h want 1/0016000f/05", out_valid, out_result, out_dst);
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_op(32'h00AB_0000 + i, 32'h0000_0CD0 + i, 5'(5'h08 + i));
      step();
    end
    idle();
    compared++;
    if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL ar_pre_valid: got %b want 1", out_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || out_count !== 3'd0) begin
      mismatched++; $display("[TB] FAIL ar_state: got valid %b count %0d want 0/0", out_valid, out_count);
    end
    compared++;
    if (out_result !== 32'h0 || out_dst !== 5'h0) begin
      mismatched++; $display("[TB] FAIL ar_outputs: got %h/%h want 0/0", out_result, out_dst);
    end
    #10;
    reset_n = 1'b1;
    step();
    drive_op(32'h0000_0007, 32'h0000_0009, 5'h13);
    step();
    idle();
    for (int c = 0; c < 2; c++) begin
      compared++;
      if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL ar_early c=%0d: got %b want 0", c, out_valid); end
      step();
    end
    compared++;
    if (out_valid !== 1'b1 || out_result !== 32'd63 || out_dst !== 5'h13) begin
      mismatched++;
      $display("[TB] FAIL ar_fresh: got %b/%h/%h want 1/0000003f/13", out_valid, out_result, out_dst);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
